// File: rtl/celery_pkg.sv
// Shared types for the render pipeline: pixel/vertex formats and the
// scheduler's command encoding.
package celery_pkg;

    typedef logic [15:0] rgb565_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] z;
    } vertex_t;

    typedef enum logic [2:0] {
        OP_TRI         = 3'd0,
        OP_FB_CLEAR    = 3'd1,
        OP_DEPTH_CLEAR = 3'd2,
        OP_CLEAR_BOTH  = 3'd3,
        OP_FENCE       = 3'd4
    } sched_op_t;

    // op is kept as a raw 3-bit code so reserved values survive the queue and can be reported.
    typedef struct packed {
        logic [2:0] op;
        vertex_t    v0;
        vertex_t    v1;
        vertex_t    v2;
        rgb565_t    color;
    } sched_cmd_t;

    function automatic logic op_clears_fb(logic [2:0] op);
        return (op == OP_FB_CLEAR) || (op == OP_CLEAR_BOTH);
    endfunction

    function automatic logic op_clears_depth(logic [2:0] op);
        return (op == OP_DEPTH_CLEAR) || (op == OP_CLEAR_BOTH);
    endfunction

endpackage

// File: rtl/render_cmd_scheduler_fifo.sv
// Single-clock command FIFO for the render scheduler; head entry is visible
// combinationally on rdata while not empty.
import celery_pkg::*;

module sched_cmd_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  sched_cmd_t             wdata,
    input  logic                   pop,
    output sched_cmd_t             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    sched_cmd_t  mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == FULL_LEVEL);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/render_cmd_scheduler.sv
// Orders render commands from cmd_parser onto rasterizer_top: triangles flow on the
// tri_ready handshake, clears and fences wait for the pipeline to go quiet first.
import celery_pkg::*;

module render_cmd_scheduler #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CLR_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  vertex_t                cmd_v0,
    input  vertex_t                cmd_v1,
    input  vertex_t                cmd_v2,
    input  rgb565_t                cmd_color,
    output vertex_t                v0,
    output vertex_t                v1,
    output vertex_t                v2,
    output logic                   tri_valid,
    input  logic                   tri_ready,
    input  logic                   rast_busy,
    output logic                   fb_clear,
    output rgb565_t                fb_clear_color,
    input  logic                   fb_clearing,
    output logic                   depth_clear,
    input  logic                   depth_clearing,
    output logic                   fence_done,
    output logic                   op_err,
    output logic                   clr_err,
    output logic                   sched_busy,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRI       = 3'd1;
    localparam logic [2:0] ST_DRAIN     = 3'd2;
    localparam logic [2:0] ST_CLR_START = 3'd3;
    localparam logic [2:0] ST_CLR_WAIT  = 3'd4;
    localparam logic [2:0] ST_FENCE     = 3'd5;

    localparam int unsigned CW = $clog2(CLR_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLR_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_GRACE = CW'(2);

    sched_cmd_t    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    logic [2:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    vertex_t       v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    rgb565_t       color_q, color_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          op_err_q, op_err_d;
    logic          clr_err_q, clr_err_d;
    logic          pipe_quiet;
    logic          sel_clearing;

    sched_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata ('{op: cmd_op, v0: cmd_v0, v1: cmd_v1, v2: cmd_v2, color: cmd_color}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign pipe_quiet   = !rast_busy && !fb_clearing && !depth_clearing;
    assign sel_clearing = (op_clears_fb(op_q) && fb_clearing) ||
                          (op_clears_depth(op_q) && depth_clearing);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        color_d    = color_q;
        wait_cnt_d = wait_cnt_q;
        op_err_d   = 1'b0;
        clr_err_d  = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    op_d = fifo_head.op;
                    case (fifo_head.op)
                        OP_TRI: begin
                            v0_d    = fifo_head.v0;
                            v1_d    = fifo_head.v1;
                            v2_d    = fifo_head.v2;
                            state_d = ST_TRI;
                        end
                        OP_FB_CLEAR, OP_CLEAR_BOTH: begin
                            color_d = fifo_head.color;
                            state_d = ST_DRAIN;
                        end
                        OP_DEPTH_CLEAR, OP_FENCE: state_d = ST_DRAIN;
                        default: op_err_d = 1'b1;
                    endcase
                end
            end
            ST_TRI: begin
                if (tri_ready) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (pipe_quiet) state_d = (op_q == OP_FENCE) ? ST_FENCE : ST_CLR_START;
            end
            ST_CLR_START: begin
                wait_cnt_d = '0;
                state_d    = ST_CLR_WAIT;
            end
            ST_CLR_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // Clearing flags lag the strobe, so the first two cycles cannot signal completion.
                if (wait_cnt_q >= CNT_GRACE && !sel_clearing) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    clr_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_FENCE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            v0_q       <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            color_q    <= '0;
            wait_cnt_q <= '0;
            op_err_q   <= 1'b0;
            clr_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            color_q    <= color_d;
            wait_cnt_q <= wait_cnt_d;
            op_err_q   <= op_err_d;
            clr_err_q  <= clr_err_d;
        end
    end

    assign cmd_ready      = !fifo_full;
    assign v0             = v0_q;
    assign v1             = v1_q;
    assign v2             = v2_q;
    assign fb_clear_color = color_q;
    assign tri_valid      = (state_q == ST_TRI);
    assign fb_clear       = (state_q == ST_CLR_START) && op_clears_fb(op_q);
    assign depth_clear    = (state_q == ST_CLR_START) && op_clears_depth(op_q);
    assign fence_done     = (state_q == ST_FENCE);
    assign op_err         = op_err_q;
    assign clr_err        = clr_err_q;
    assign sched_busy     = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_render_cmd_scheduler.sv
// Bench for render_cmd_scheduler: directed ordering/timing scenarios, then random
// traffic scored against an in-order command queue and a simple clear-engine model.
import celery_pkg::*;

module tb_render_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    vertex_t    cmd_v0, cmd_v1, cmd_v2, v0, v1, v2;
    rgb565_t    cmd_color, fb_clear_color;
    logic       tri_valid, tri_ready, rast_busy;
    logic       fb_clear, fb_clearing, depth_clear, depth_clearing;
    logic       fence_done, op_err, clr_err, sched_busy;
    logic [3:0] fifo_level;

    render_cmd_scheduler #(
        .DEPTH       (8),
        .CLR_TIMEOUT (100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_v0         (cmd_v0),
        .cmd_v1         (cmd_v1),
        .cmd_v2         (cmd_v2),
        .cmd_color      (cmd_color),
        .v0             (v0),
        .v1             (v1),
        .v2             (v2),
        .tri_valid      (tri_valid),
        .tri_ready      (tri_ready),
        .rast_busy      (rast_busy),
        .fb_clear       (fb_clear),
        .fb_clear_color (fb_clear_color),
        .fb_clearing    (fb_clearing),
        .depth_clear    (depth_clear),
        .depth_clearing (depth_clearing),
        .fence_done     (fence_done),
        .op_err         (op_err),
        .clr_err        (clr_err),
        .sched_busy     (sched_busy),
        .fifo_level     (fifo_level)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    sched_cmd_t exp_q[$];
    int         hs_q[$];
    rgb565_t    last_color;
    int fb_n = 0, dp_n = 0, fence_n = 0, err_n = 0, clrerr_n = 0;
    int fb_cyc, dp_cyc, fence_cyc, clrerr_cyc, dp_fall_cyc;
    bit strict = 1'b0;
    bit rand_len = 1'b0;
    int fb_len = 20, dp_len = 20;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vertex_t rand_vtx();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    function automatic logic [2:0] rand_op();
        int r;
        r = $urandom_range(0, 15);
        if (r < 7)  return OP_TRI;
        if (r < 9)  return OP_FB_CLEAR;
        if (r == 9) return OP_DEPTH_CLEAR;
        if (r == 10) return OP_CLEAR_BOTH;
        if (r < 14) return OP_FENCE;
        return 3'(5 + $urandom_range(0, 2));
    endfunction

    task automatic drive(input logic [2:0] op, input rgb565_t col);
        cmd_op    = op;
        cmd_v0    = rand_vtx();
        cmd_v1    = rand_vtx();
        cmd_v2    = rand_vtx();
        cmd_color = col;
    endtask

    // Presents one command and holds it until accepted; returns one cycle later.
    task automatic push(input logic [2:0] op, input rgb565_t col);
        bit ok;
        ok = 1'b0;
        drive(op, col);
        cmd_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        check("push_accept", ok, 1);
    endtask

    task automatic pop_head(output sched_cmd_t h, output bit ok);
        ok = exp_q.size() > 0;
        h  = ok ? exp_q.pop_front() : '0;
        check("event_has_cmd", ok, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Clear-engine model: clearing flag rises the cycle after a strobe for a set length.
    initial begin
        int fb_left, dp_left;
        fb_left = 0;
        dp_left = 0;
        fb_clearing = 1'b0;
        depth_clearing = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && fb_clear)    fb_left = rand_len ? $urandom_range(3, 30) : fb_len;
            if (rst_n && depth_clear) dp_left = rand_len ? $urandom_range(3, 30) : dp_len;
            step();
            if (!rst_n) begin
                fb_left = 0;
                dp_left = 0;
            end
            fb_clearing    = fb_left > 0;
            depth_clearing = dp_left > 0;
            if (fb_left > 0) fb_left--;
            if (dp_left > 0) dp_left--;
        end
    end

    // Scoreboard: every retirement event must match the oldest accepted command.
    initial begin
        sched_cmd_t h;
        bit ok;
        logic pr_busy, pr_fb, pr_dp;
        logic [2:0] kind;
        pr_busy = 1'b0;
        pr_fb = 1'b0;
        pr_dp = 1'b0;
        last_color = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                last_color = '0;
            end else begin
                if (op_err) begin
                    err_n++;
                    pop_head(h, ok);
                    if (ok) check("err_op_reserved", h.op >= 3'd5, 1);
                end
                if (tri_valid && tri_ready) begin
                    hs_q.push_back(cyc);
                    pop_head(h, ok);
                    if (ok) begin
                        check("tri_op", h.op, OP_TRI);
                        check("tri_v0", v0, h.v0);
                        check("tri_v1", v1, h.v1);
                        check("tri_v2", v2, h.v2);
                    end
                    if (strict) check("tri_during_clear", {fb_clearing, depth_clearing}, 0);
                end
                if (fb_clear || depth_clear) begin
                    kind = (fb_clear && depth_clear) ? OP_CLEAR_BOTH :
                           fb_clear ? OP_FB_CLEAR : OP_DEPTH_CLEAR;
                    if (fb_clear) begin fb_n++; fb_cyc = cyc; end
                    if (depth_clear) begin dp_n++; dp_cyc = cyc; end
                    pop_head(h, ok);
                    if (ok) begin
                        check("clr_op", kind, h.op);
                        if (h.op == OP_FB_CLEAR || h.op == OP_CLEAR_BOTH) last_color = h.color;
                    end
                    check("clr_color", fb_clear_color, last_color);
                    check("clr_after_drain", {pr_busy, pr_fb, pr_dp}, 0);
                end
                if (fence_done) begin
                    fence_n++;
                    fence_cyc = cyc;
                    pop_head(h, ok);
                    if (ok) check("fence_op", h.op, OP_FENCE);
                    check("fence_after_drain", {pr_busy, pr_fb, pr_dp}, 0);
                end
                if (clr_err) begin
                    clrerr_n++;
                    clrerr_cyc = cyc;
                end
                if (pr_dp && !depth_clearing) dp_fall_cyc = cyc;
                if (cmd_valid && cmd_ready)
                    exp_q.push_back('{op: cmd_op, v0: cmd_v0, v1: cmd_v1, v2: cmd_v2,
                                      color: cmd_color});
            end
            pr_busy = rast_busy;
            pr_fb   = fb_clearing;
            pr_dp   = depth_clearing;
        end
    end

    initial begin
        int c0, b, n0, fall, idle, acc;
        logic last_acc;
        vertex_t e0, e1, e2;
        logic [2:0] ops9 [9];

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        tri_ready = 1'b0;
        rast_busy = 1'b0;
        drive(OP_TRI, '0);
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_strobes", {tri_valid, fb_clear, depth_clear, fence_done, op_err, clr_err}, 0);
        check("rst_busy_level", {sched_busy, fifo_level}, 0);
        check("rst_vtx_color", {v0, fb_clear_color}, 0);
        rst_n = 1'b1;
        step();

        // Three back-to-back triangles, tri_ready high.
        tri_ready = 1'b1;
        c0 = cyc;
        b = hs_q.size();
        n0 = fence_n;
        push(OP_TRI, '0);
        push(OP_TRI, '0);
        push(OP_TRI, '0);
        for (int k = 0; k < 20 && hs_q.size() < b + 3; k++) step();
        check("tri3_count", hs_q.size() - b, 3);
        if (hs_q.size() >= b + 3) begin
            check("tri3_hs0_cyc", hs_q[b] - c0, 2);
            check("tri3_hs1_cyc", hs_q[b + 1] - c0, 4);
            check("tri3_hs2_cyc", hs_q[b + 2] - c0, 6);
        end
        check("tri3_no_fence", fence_n - n0, 0);

        // Stalled triangle: outputs hold for 10 cycles.
        tri_ready = 1'b0;
        push(OP_TRI, '0);
        e0 = cmd_v0;
        e1 = cmd_v1;
        e2 = cmd_v2;
        for (int k = 0; k < 10 && !tri_valid; k++) step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_valid", tri_valid, 1);
            check("stall_v0", v0, e0);
            check("stall_v1", v1, e1);
            check("stall_v2", v2, e2);
            step();
        end

        // Fill the queue behind the stalled triangle; the 9th must be refused.
        ops9 = '{OP_TRI, OP_TRI, 3'd7, OP_FENCE, OP_TRI, OP_TRI, OP_TRI, OP_TRI, OP_TRI};
        acc = 0;
        last_acc = 1'b0;
        n0 = err_n;
        b = fence_n;
        for (int i = 0; i < 9; i++) begin
            drive(ops9[i], '0);
            cmd_valid = 1'b1;
            @(negedge clk);
            acc += int'(cmd_ready);
            last_acc = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        check("full_accepted", acc, 8);
        check("full_ninth_refused", last_acc, 0);
        check("full_level", fifo_level, 8);
        check("full_cmd_ready", cmd_ready, 0);
        tri_ready = 1'b1;
        for (int k = 0; k < 300 && (sched_busy || exp_q.size() != 0); k++) step();
        check("full_drained", {sched_busy, fifo_level}, 0);
        check("full_op_err_once", err_n - n0, 1);
        check("full_fence_once", fence_n - b, 1);

        // Clear waits for rast_busy to fall.
        fb_len = 50;
        n0 = fb_n;
        b = hs_q.size();
        push(OP_TRI, '0);
        push(OP_FB_CLEAR, 16'hF800);
        for (int k = 0; k < 50 && hs_q.size() == b; k++) step();
        rast_busy = 1'b1;
        repeat (20) begin
            step();
        end
        check("busy_no_clear", fb_n - n0, 0);
        rast_busy = 1'b0;
        fall = cyc;
        for (int k = 0; k < 200 && sched_busy; k++) step();
        idle = cyc;
        check("busy_idle", sched_busy, 0);
        check("busy_fb_once", fb_n - n0, 1);
        check("busy_fb_cyc", fb_cyc - fall, 1);
        check("busy_fb_color", fb_clear_color, 16'hF800);
        check("busy_wait_len", (idle - fb_cyc) >= 50, 1);

        // Combined clear then fence; depth clear outlasts framebuffer clear.
        fb_len = 10;
        dp_len = 40;
        n0 = fence_n;
        b = dp_n;
        push(OP_CLEAR_BOTH, 16'h07E0);
        push(OP_FENCE, '0);
        for (int k = 0; k < 400 && fence_n == n0; k++) step();
        repeat (5) step();
        check("both_fence_once", fence_n - n0, 1);
        check("both_depth_once", dp_n - b, 1);
        check("both_same_cycle", fb_cyc, dp_cyc);
        check("both_color", fb_clear_color, 16'h07E0);
        check("both_dp_fall_late", (dp_fall_cyc - dp_cyc) >= 40, 1);
        check("both_fence_after_dp", fence_cyc > dp_fall_cyc, 1);

        // Stuck fb_clearing: timeout, then the queued triangle still issues.
        fb_len = 1000;
        n0 = clrerr_n;
        b = hs_q.size();
        push(OP_FB_CLEAR, 16'h001F);
        push(OP_TRI, '0);
        for (int k = 0; k < 400 && clrerr_n == n0; k++) step();
        check("tmo_clr_err_once", clrerr_n - n0, 1);
        check("tmo_clr_err_cyc", clrerr_cyc - fb_cyc, 101);
        for (int k = 0; k < 20 && hs_q.size() == b; k++) step();
        check("tmo_tri_issued", hs_q.size() - b, 1);

        // Reset in the middle of a stalled triangle with more queued.
        tri_ready = 1'b0;
        push(OP_TRI, '0);
        push(OP_FENCE, '0);
        for (int k = 0; k < 10 && !tri_valid; k++) step();
        #4 rst_n = 1'b0;
        #1;
        check("rst_mid_tri_valid", tri_valid, 0);
        check("rst_mid_level", fifo_level, 0);
        check("rst_mid_ready", cmd_ready, 1);
        fb_len = 20;
        dp_len = 20;
        step();
        step();
        rst_n = 1'b1;
        tri_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_rel_quiet", {tri_valid, fb_clear, depth_clear, fence_done, sched_busy}, 0);
            step();
        end

        // Random traffic against the scoreboard.
        strict = 1'b1;
        rand_len = 1'b1;
        n0 = clrerr_n;
        for (int i = 0; i < 600; i++) begin
            cmd_valid = $urandom_range(0, 2) != 0;
            drive(rand_op(), 16'($urandom));
            tri_ready = $urandom_range(0, 3) != 0;
            rast_busy = $urandom_range(0, 3) == 0;
            step();
        end
        cmd_valid = 1'b0;
        tri_ready = 1'b1;
        rast_busy = 1'b0;
        for (int k = 0; k < 8000 && (sched_busy || exp_q.size() != 0); k++) step();
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_idle", sched_busy, 0);
        check("rand_no_timeout", clrerr_n - n0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
